// File: rtl/amp_switch_cfg_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// amp_switch_cfg_sequencer_pkg: shared types, defaults and frame packing
// Revision: 1.0
// ---------------------------------------------------------------------------
package amp_switch_cfg_sequencer_pkg;

  localparam int unsigned START_LOW_CYC_DEF = 4;
  localparam int unsigned TIMEOUT_CYC_DEF   = 4096;

  localparam int unsigned MODE_BIT_1595 = 0;
  localparam int unsigned MODE_BIT_595  = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START_LOW = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_WAIT_CLR  = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  typedef enum logic {
    PH_1595 = 1'b0,
    PH_595  = 1'b1
  } phase_t;

  typedef logic [3:0][31:0] frame_t;

  // Word k of the 1595 frame is the adjacent code pair {code[2k+1], code[2k]}.
  function automatic logic [31:0] pack1595(input logic [127:0] dac_codes,
                                           input logic [1:0]   index);
    return dac_codes[{index, 5'd0} +: 32];
  endfunction

  function automatic logic [31:0] pack595(input logic [63:0] sw_codes,
                                          input logic [1:0]  index);
    logic [15:0] pair;
    pair = sw_codes[{index, 4'd0} +: 16];
    return {pair[15:8], 8'h00, pair[7:0], 8'h00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/amp_switch_cfg_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// amp_switch_cfg_sequencer_if: CPU request side and serializer side signals
// Revision: 1.0
// ---------------------------------------------------------------------------
interface amp_switch_cfg_sequencer_if;

  logic         cfg_req;
  logic [1:0]   cfg_mode;
  logic [127:0] dac_codes;
  logic [63:0]  sw_codes;
  logic         cfg_busy;
  logic         cfg_done;
  logic         cfg_err;

  logic         ser_start;
  logic         ser_ld1595_en;
  logic         ser_ld595_en;
  logic [31:0]  ser_din0;
  logic [31:0]  ser_din1;
  logic [31:0]  ser_din2;
  logic [31:0]  ser_din3;
  logic         ser_config_done;

  modport master (
    output cfg_req, cfg_mode, dac_codes, sw_codes, ser_config_done,
    input  cfg_busy, cfg_done, cfg_err, ser_start, ser_ld1595_en,
           ser_ld595_en, ser_din0, ser_din1, ser_din2, ser_din3
  );

  modport slave (
    input  cfg_req, cfg_mode, dac_codes, sw_codes, ser_config_done,
    output cfg_busy, cfg_done, cfg_err, ser_start, ser_ld1595_en,
           ser_ld595_en, ser_din0, ser_din1, ser_din2, ser_din3
  );

endinterface
`default_nettype wire

// File: rtl/amp_switch_cfg_sequencer_cfg_timeout_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfg_timeout_counter: clear/enable up-counter flagging when it equals limit
// Revision: 1.0
// ---------------------------------------------------------------------------
module cfg_timeout_counter #(
  parameter int unsigned WIDTH = 13
) (
  input  wire logic             clkin,
  input  wire logic             rst_n,
  input  wire logic             load_i,
  input  wire logic             en_i,
  input  wire logic [WIDTH-1:0] limit_i,
  output logic                  expired_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == limit_i);

endmodule
`default_nettype wire

// File: rtl/amp_switch_cfg_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// amp_switch_cfg_sequencer: packs amp/switch codes, runs 1595/595 frames
// Revision: 1.0
// ---------------------------------------------------------------------------
module amp_switch_cfg_sequencer
  import amp_switch_cfg_sequencer_pkg::*;
#(
  parameter int unsigned START_LOW_CYC = START_LOW_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
  input wire logic                  clkin,
  input wire logic                  rst_n,
  amp_switch_cfg_sequencer_if.slave bus_if
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] START_LIMIT   = CNT_W'(START_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  state_t         state_q, state_d;
  phase_t         phase_q, phase_d;
  logic [1:0]     mode_q, mode_d;
  logic [127:0]   dac_q, dac_d;
  logic [63:0]    sw_q, sw_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           start_q, start_d;
  logic           ld1595_q, ld1595_d;
  logic           ld595_q, ld595_d;
  frame_t         din_q, din_d;

  logic           cnt_load;
  logic           cnt_en;
  logic [CNT_W-1:0] cnt_limit;
  logic           cnt_expired;

  function automatic frame_t frame_words(input phase_t       ph,
                                         input logic [127:0] dac,
                                         input logic [63:0]  sw);
    frame_t f;
    for (int k = 0; k < 4; k++) begin
      f[k] = (ph == PH_1595) ? pack1595(dac, 2'(k)) : pack595(sw, 2'(k));
    end
    return f;
  endfunction

  cfg_timeout_counter #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .en_i      (cnt_en),
    .limit_i   (cnt_limit),
    .expired_o (cnt_expired)
  );

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_1595;
      mode_q   <= '0;
      dac_q    <= '0;
      sw_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      ld1595_q <= 1'b0;
      ld595_q  <= 1'b0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      mode_q   <= mode_d;
      dac_q    <= dac_d;
      sw_q     <= sw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      start_q  <= start_d;
      ld1595_q <= ld1595_d;
      ld595_q  <= ld595_d;
      din_q    <= din_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    mode_d    = mode_q;
    dac_d     = dac_q;
    sw_d      = sw_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    start_d   = start_q;
    ld1595_d  = ld1595_q;
    ld595_d   = ld595_q;
    din_d     = din_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_limit = START_LIMIT;

    unique case (state_q)
      ST_IDLE: begin
        if (bus_if.cfg_req) begin
          mode_d = bus_if.cfg_mode;
          dac_d  = bus_if.dac_codes;
          sw_d   = bus_if.sw_codes;
          err_d  = 1'b0;
          busy_d = 1'b1;
          if (bus_if.cfg_mode == 2'b00) begin
            state_d = ST_FINISH;
          end else begin
            // Drive the first frame straight from the request so data and
            // enables are valid one cycle after acceptance.
            phase_d  = bus_if.cfg_mode[MODE_BIT_1595] ? PH_1595 : PH_595;
            din_d    = frame_words(phase_d, bus_if.dac_codes, bus_if.sw_codes);
            ld1595_d = (phase_d == PH_1595);
            ld595_d  = (phase_d == PH_595);
            state_d  = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        din_d    = frame_words(phase_q, dac_q, sw_q);
        ld1595_d = (phase_q == PH_1595);
        ld595_d  = (phase_q == PH_595);
        start_d  = 1'b0;
        cnt_load = 1'b1;
        state_d  = ST_START_LOW;
      end

      ST_START_LOW: begin
        cnt_en    = 1'b1;
        cnt_limit = START_LIMIT;
        if (cnt_expired) begin
          start_d  = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        cnt_en    = 1'b1;
        cnt_limit = TIMEOUT_LIMIT;
        if (bus_if.ser_config_done) begin
          start_d  = 1'b0;
          cnt_load = 1'b1;
          state_d  = ST_WAIT_CLR;
        end else if (cnt_expired) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end

      ST_WAIT_CLR: begin
        cnt_en    = 1'b1;
        cnt_limit = TIMEOUT_LIMIT;
        if (!bus_if.ser_config_done) begin
          if (mode_q == 2'b11 && phase_q == PH_1595) begin
            phase_d = PH_595;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_FINISH;
          end
        end else if (cnt_expired) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        start_d  = 1'b0;
        ld1595_d = 1'b0;
        ld595_d  = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus_if.cfg_busy      = busy_q;
  assign bus_if.cfg_done      = done_q;
  assign bus_if.cfg_err       = err_q;
  assign bus_if.ser_start     = start_q;
  assign bus_if.ser_ld1595_en = ld1595_q;
  assign bus_if.ser_ld595_en  = ld595_q;
  assign bus_if.ser_din0      = din_q[0];
  assign bus_if.ser_din1      = din_q[1];
  assign bus_if.ser_din2      = din_q[2];
  assign bus_if.ser_din3      = din_q[3];

endmodule
`default_nettype wire

// File: tb/tb_amp_switch_cfg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_amp_switch_cfg_sequencer: randomized requests against a frame-list model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_amp_switch_cfg_sequencer;

  localparam int unsigned S      = 4;
  localparam int unsigned T      = 4096;
  localparam int unsigned BUDGET = 3 * T;

  logic clkin = 1'b0;
  logic rst_n = 1'b0;

  amp_switch_cfg_sequencer_if bus_if();

  amp_switch_cfg_sequencer #(
    .START_LOW_CYC (S),
    .TIMEOUT_CYC   (T)
  ) dut (
    .clkin  (clkin),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  always #20 clkin = ~clkin;

  int unsigned cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Frame = {ld1595, ld595, din3, din2, din1, din0}
  function automatic logic [129:0] cur_frame();
    return {bus_if.ser_ld1595_en, bus_if.ser_ld595_en, bus_if.ser_din3,
            bus_if.ser_din2, bus_if.ser_din1, bus_if.ser_din0};
  endfunction

  function automatic logic [133:0] all_outputs();
    return {bus_if.cfg_busy, bus_if.cfg_done, bus_if.cfg_err, bus_if.ser_start, cur_frame()};
  endfunction

  // Reference: split the codes into the eight named channels and pair them up.
  function automatic logic [129:0] exp_frame(input bit is1595, input logic [127:0] dac,
                                             input logic [63:0] sw);
    logic [15:0] d [8];
    logic [7:0]  s [8];
    logic [31:0] w [4];
    for (int i = 0; i < 8; i++) begin
      d[i] = dac[i*16 +: 16];
      s[i] = sw[i*8 +: 8];
    end
    for (int k = 0; k < 4; k++) begin
      w[k] = is1595 ? {d[2*k+1], d[2*k]} : {s[2*k+1], 8'h00, s[2*k], 8'h00};
    end
    return {is1595, !is1595, w[3], w[2], w[1], w[0]};
  endfunction

  bit             hang = 1'b0;
  int             n_rise, n_done, stab_viol, onehot_viol, gap_min;
  int             low_len = 0, cur_hi = 0, last_hi = 0;
  int unsigned    first_rise_cyc;
  logic [129:0]   seen_q[$];
  logic           prev_start = 1'b0, prev_done = 1'b0;
  logic [129:0]   prev_fr = '0;
  int             m_cnt = 0, m_lat = 2;

  // Monitor first, then the serializer model, all on the falling edge.
  initial begin
    bus_if.ser_config_done = 1'b0;
    forever begin
      @(negedge clkin);
      if (!rst_n) begin
        prev_start = 1'b0;
        prev_done  = 1'b0;
        cur_hi     = 0;
        low_len    = 0;
        m_cnt      = 0;
        bus_if.ser_config_done = 1'b0;
      end else begin
        if (bus_if.ser_start && !prev_start) begin
          seen_q.push_back(cur_frame());
          if (n_rise == 0) first_rise_cyc = cyc;
          else if (low_len < gap_min) gap_min = low_len;
          n_rise++;
        end
        if (bus_if.ser_start) begin
          cur_hi++;
          low_len = 0;
        end else begin
          if (prev_start) last_hi = cur_hi;
          cur_hi = 0;
          low_len++;
        end
        if ((prev_start || prev_done) && cur_frame() !== prev_fr) stab_viol++;
        if (bus_if.ser_start && (bus_if.ser_ld1595_en == bus_if.ser_ld595_en)) onehot_viol++;
        if (bus_if.cfg_done) n_done++;
        prev_start = bus_if.ser_start;
        prev_done  = bus_if.ser_config_done;
        prev_fr    = cur_frame();

        if (!bus_if.ser_config_done && bus_if.ser_start && !hang) begin
          m_cnt++;
          if (m_cnt >= m_lat) begin
            bus_if.ser_config_done = 1'b1;
            m_cnt = 0;
            m_lat = $urandom_range(1, 5);
          end
        end else if (bus_if.ser_config_done && !bus_if.ser_start) begin
          m_cnt++;
          if (m_cnt >= m_lat) begin
            bus_if.ser_config_done = 1'b0;
            m_cnt = 0;
            m_lat = $urandom_range(1, 5);
          end
        end else begin
          m_cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clkin);
    #1;
  endtask

  task automatic clear_monitor();
    seen_q.delete();
    n_rise      = 0;
    n_done      = 0;
    stab_viol   = 0;
    onehot_viol = 0;
    gap_min     = 1000000;
  endtask

  function automatic logic [127:0] rand_dac();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand_sw();
    return {$urandom, $urandom};
  endfunction

  task automatic run_req(input logic [1:0] mode, input logic [127:0] dac,
                         input logic [63:0] sw, input bit hang_i);
    logic [129:0] exp_q[$];
    int unsigned  req_cyc;
    int           k;
    bit           exp_err;

    if (mode[0]) exp_q.push_back(exp_frame(1'b1, dac, sw));
    if (mode[1] && !(hang_i && mode[0])) exp_q.push_back(exp_frame(1'b0, dac, sw));
    exp_err = hang_i && (mode != 2'b00);

    hang = hang_i;
    clear_monitor();
    bus_if.cfg_req   = 1'b1;
    bus_if.cfg_mode  = mode;
    bus_if.dac_codes = dac;
    bus_if.sw_codes  = sw;
    step();
    req_cyc = cyc;
    // Scramble the inputs so any later use must come from latched values.
    bus_if.cfg_req   = 1'b0;
    bus_if.cfg_mode  = 2'(~mode);
    bus_if.dac_codes = rand_dac();
    bus_if.sw_codes  = rand_sw();
    check("busy_on_accept", bus_if.cfg_busy, 1'b1);
    if (mode != 2'b00) check("frame_on_accept", cur_frame(), exp_q[0]);

    k = 1;
    while (!bus_if.cfg_done && k < int'(BUDGET)) begin
      step();
      k++;
    end
    check("done_seen", bus_if.cfg_done, 1'b1);
    if (mode == 2'b00) check("done_latency_mode0", k, 2);
    check("err_flag", bus_if.cfg_err, exp_err);
    check("busy_at_done", bus_if.cfg_busy, 1'b0);
    step();
    check("done_one_cycle", bus_if.cfg_done, 1'b0);
    check("enables_idle", {bus_if.ser_ld1595_en, bus_if.ser_ld595_en, bus_if.ser_start}, 3'b000);
    check("done_count", n_done, 1);
    check("frame_count", seen_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      check($sformatf("frame%0d", i), seen_q[i], exp_q[i]);
    end
    if (mode != 2'b00) check("start_rise_latency", first_rise_cyc - req_cyc, S + 1);
    if (mode == 2'b11 && !hang_i) check("interphase_gap_ok", gap_min >= int'(S + 1), 1'b1);
    if (exp_err) check("timeout_len_ok", (last_hi >= int'(T) && last_hi <= int'(T + 1)), 1'b1);
    check("stable_while_busy", stab_viol, 0);
    check("onehot_enables", onehot_viol, 0);
    hang = 1'b0;
  endtask

  initial begin
    logic [127:0] dac;
    logic [63:0]  sw;
    int           k;

    bus_if.cfg_req   = 1'b0;
    bus_if.cfg_mode  = 2'b00;
    bus_if.dac_codes = '0;
    bus_if.sw_codes  = '0;
    clear_monitor();
    repeat (3) step();
    check("reset_outputs", all_outputs(), '0);
    rst_n = 1'b1;
    step();

    dac = rand_dac();
    dac[31:0] = 32'hABCD_1234;
    run_req(2'b01, dac, rand_sw(), 1'b0);
    check("mode01_din0", bus_if.ser_din0, 32'hABCD_1234);

    sw = rand_sw();
    sw[15:0] = 16'hC35A;
    run_req(2'b10, rand_dac(), sw, 1'b0);
    check("mode10_din0", bus_if.ser_din0, 32'hC300_5A00);

    run_req(2'b11, rand_dac(), rand_sw(), 1'b0);
    run_req(2'b11, rand_dac(), rand_sw(), 1'b1);
    run_req(2'b00, rand_dac(), rand_sw(), 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_req(2'($urandom_range(0, 3)), rand_dac(), rand_sw(), 1'b0);
    end

    // Busy request is dropped, then reset lands during WAIT_DONE.
    dac = rand_dac();
    sw  = rand_sw();
    hang = 1'b1;
    clear_monitor();
    bus_if.cfg_req   = 1'b1;
    bus_if.cfg_mode  = 2'b01;
    bus_if.dac_codes = dac;
    bus_if.sw_codes  = sw;
    step();
    bus_if.cfg_req = 1'b0;
    k = 0;
    while (!bus_if.ser_start && k < 50) begin
      step();
      k++;
    end
    check("start_before_reset", bus_if.ser_start, 1'b1);
    bus_if.cfg_req   = 1'b1;
    bus_if.cfg_mode  = 2'b10;
    bus_if.dac_codes = rand_dac();
    bus_if.sw_codes  = rand_sw();
    step();
    bus_if.cfg_req = 1'b0;
    check("busy_req_ignored", cur_frame(), exp_frame(1'b1, dac, sw));
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("midop_reset_outputs", all_outputs(), '0);
    rst_n = 1'b1;
    hang  = 1'b0;
    repeat (3) step();
    check("no_queued_request", bus_if.cfg_busy, 1'b0);
    run_req(2'b11, rand_dac(), rand_sw(), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
